// File: rtl/issue_unit_pkg.sv
// issue_unit_pkg: shared widths, opcodes and instruction classification for the issue stage.
package issue_unit_pkg;
  localparam int WORD_SIZE = 32;
  localparam int OPCODE_WIDTH = 6;
  localparam int FU_NUM = 4;
  localparam int FU_INDEX = 3;
  localparam int RB_INDEX = 4;
  localparam int ADD_FU_NUM_DEF = 2;
  localparam int CNT_W_DEF = 16;
  localparam logic [FU_INDEX-1:0] FU_IDLE_DEF = '1;
  localparam logic [RB_INDEX-1:0] RB_NULL = '1;
  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ADD = 6'd1,
    OP_ADDI = 6'd2,
    OP_SUB = 6'd3,
    OP_SUBI = 6'd4,
    OP_MUL = 6'd5,
    OP_MULI = 6'd6
  } opcode_e;
  typedef enum logic [1:0] {CLS_ADD, CLS_MUL, CLS_ILL} op_class_e;
  typedef enum logic {EMPTY, HELD} hold_e;
  function automatic op_class_e classify(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ADD || op == OP_ADDI || op == OP_SUB || op == OP_SUBI) ? CLS_ADD :
           (op == OP_MUL || op == OP_MULI) ? CLS_MUL : CLS_ILL;
  endfunction
endpackage

// File: rtl/fu_select.sv
// fu_select: combinational lowest-index pick over an availability mask.
module fu_select #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic [N-1:0] avail,
  output logic         found,
  output logic [W-1:0] index
);
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (avail[i]) begin
        found = 1'b1;
        index = W'(i);
      end
    end
  end
endmodule

// File: rtl/issue_unit.sv
// issue_unit: in-order issue stage that picks a free RS and broadcasts <fu, RB_index, inst>.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int ADD_FU_NUM = ADD_FU_NUM_DEF,
  parameter logic [FU_INDEX-1:0] FU_IDLE = FU_IDLE_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_valid,
  input  logic [WORD_SIZE-1:0] inst_in,
  output logic                 inst_ready,
  input  logic [FU_NUM-1:0]    busy_bus,
  input  logic                 rb_free,
  input  logic [RB_INDEX-1:0]  rb_tail,
  output logic                 rb_alloc,
  output logic [FU_INDEX-1:0]  fu,
  output logic [RB_INDEX-1:0]  RB_index,
  output logic [WORD_SIZE-1:0] inst,
  output logic                 illegal,
  output logic [CNT_W-1:0]     issue_count,
  output logic [CNT_W-1:0]     stall_count
);
  hold_e state_q, state_d;
  logic [WORD_SIZE-1:0] held_inst_q, held_inst_d, inst_q, inst_d;
  logic [FU_NUM-1:0] claim_q, claim_d, class_mask, avail;
  logic [FU_INDEX-1:0] fu_q, fu_d, cand;
  logic [RB_INDEX-1:0] rb_q, rb_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;
  logic illegal_q, illegal_d, found, held_v, legal, issue_now, accept;
  op_class_e cls;
  assign held_v = state_q == HELD;
  assign cls = classify(held_inst_q[WORD_SIZE-1 -: OPCODE_WIDTH]);
  assign legal = cls != CLS_ILL;
  always_comb begin
    class_mask = '0;
    for (int i = 0; i < FU_NUM; i++)
      class_mask[i] = cls == CLS_ADD ? (i < ADD_FU_NUM) : cls == CLS_MUL ? (i >= ADD_FU_NUM) : 1'b0;
  end
  // claim hides the FU issued last edge until its RS has raised busy
  assign avail = class_mask & ~busy_bus & ~claim_q;
  fu_select #(.N(FU_NUM), .W(FU_INDEX)) u_fu_select (
    .avail(avail),
    .found(found),
    .index(cand)
  );
  assign issue_now = held_v && legal && found && rb_free && !reset;
  assign inst_ready = !reset && (!held_v || issue_now);
  assign accept = inst_valid && inst_ready;
  assign rb_alloc = issue_now;
  always_comb begin
    state_d = accept ? HELD : (issue_now || !legal) ? EMPTY : state_q;
    held_inst_d = accept ? inst_in : held_inst_q;
    fu_d = issue_now ? cand : FU_IDLE;
    rb_d = issue_now ? rb_tail : RB_NULL;
    inst_d = issue_now ? held_inst_q : inst_q;
    claim_d = issue_now ? FU_NUM'(1) << cand : '0;
    illegal_d = held_v && !legal;
    issue_cnt_d = issue_cnt_q + CNT_W'(issue_now && issue_cnt_q != '1);
    stall_cnt_d = stall_cnt_q + CNT_W'(held_v && legal && !issue_now && stall_cnt_q != '1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      held_inst_q <= '0;
      fu_q <= FU_IDLE;
      rb_q <= RB_NULL;
      inst_q <= '0;
      claim_q <= '0;
      illegal_q <= 1'b0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      held_inst_q <= held_inst_d;
      fu_q <= fu_d;
      rb_q <= rb_d;
      inst_q <= inst_d;
      claim_q <= claim_d;
      illegal_q <= illegal_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign fu = fu_q;
  assign RB_index = rb_q;
  assign inst = inst_q;
  assign illegal = illegal_q;
  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;
endmodule
